// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver (8 data bits, optional parity, 1 stop)
//
// The line is examined only on BaudTick (OVERSAMPLE ticks per bit).
// A start bit is detected on a high-to-low observation in IDLE. It is
// confirmed at mid-bit, and every later bit is sampled one bit period
// after the previous sample.
//
// Handshake: DataValid is a one-Clock strobe with no back-pressure. DataOut,
// ParityError and FramingError change only in the cycle where DataValid is
// high, and they hold their values until the next strobe.
//
// Parameters:
//   OVERSAMPLE   BaudTick pulses per bit period (even, >= 8)
//
// Ports:
//   Clock        system clock, rising edge
//   ResetN       asynchronous active-low reset
//   RxIn         serial line, idle high
//   BaudTick     one-Clock enable at OVERSAMPLE x baud
//   ParityType   00 none, 01 odd, 10 even, 11 none (latched at start bit)
//   DataOut      last received byte (LSB first on the line)
//   DataValid    one-Clock strobe when DataOut/ParityError/FramingError update
//   ParityError  parity mismatch of the strobed frame
//   FramingError stop bit sampled low for the strobed frame
//   Busy         high whenever the FSM is not in IDLE
//   DbgState     current FSM state encoding (IDLE=0, START=1, DATA=2,
//                PARITY=3, STOP=4, WAIT_HIGH=5)
//
// Build option:
//   UART_RX_SYNC2_EN  when defined, RxIn passes through a two-flop
//                     synchronizer (preset high) before any FSM use.
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       RxIn,
  input  logic       BaudTick,
  input  logic [1:0] ParityType,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       FramingError,
  output logic       Busy,
  output logic [2:0] DbgState
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_TICK  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);

  state_t        state;
  state_t        stateNext;
  logic [CW-1:0] tickCnt;
  logic [2:0]    bitCnt;
  logic [7:0]    shiftReg;
  logic [1:0]    parMode;
  logic          parFlag;
  logic          rxPrev;
  logic          rxS;
  logic          sampleTick;
  logic          parEn;

`ifdef UART_RX_SYNC2_EN
  logic [1:0] rxSync;

  // Preset high so that reset looks like an idle line.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) rxSync <= 2'b11;
    else         rxSync <= {rxSync[0], RxIn};
  end

  assign rxS = rxSync[1];
`else
  assign rxS = RxIn;
`endif

  // START samples at mid-bit. Every later state samples a full bit period
  // after the previous sample.
  always_comb begin
    sampleTick = 1'b0;
    if (BaudTick) begin
      if (state == START)
        sampleTick = (tickCnt == MID_TICK);
      else if (state == DATA || state == PARITY || state == STOP)
        sampleTick = (tickCnt == LAST_TICK);
    end
  end

  assign parEn = (parMode == 2'b01) || (parMode == 2'b10);

  // State register
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (BaudTick && !rxS && rxPrev) stateNext = START;
      START:     if (sampleTick) stateNext = rxS ? IDLE : DATA;
      DATA:      if (sampleTick && bitCnt == 3'd7) stateNext = parEn ? PARITY : STOP;
      PARITY:    if (sampleTick) stateNext = STOP;
      STOP:      if (sampleTick) stateNext = rxS ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (BaudTick && rxS) stateNext = IDLE;
      default:   stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy     = (state != IDLE);
    DbgState = state;
  end

  // Counters and datapath
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      tickCnt      <= '0;
      bitCnt       <= '0;
      shiftReg     <= '0;
      parMode      <= '0;
      parFlag      <= 1'b0;
      rxPrev       <= 1'b0;  // a high must be seen before the first start
      DataOut      <= '0;
      DataValid    <= 1'b0;
      ParityError  <= 1'b0;
      FramingError <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      if (BaudTick) begin
        rxPrev <= rxS;
        if (sampleTick || state == IDLE || state == WAIT_HIGH)
          tickCnt <= '0;
        else
          tickCnt <= tickCnt + 1'b1;

        case (state)
          IDLE: begin
            if (stateNext == START) begin
              parMode <= ParityType;
              parFlag <= 1'b0;
              bitCnt  <= '0;
            end
          end
          DATA: begin
            if (sampleTick) begin
              shiftReg <= {rxS, shiftReg[7:1]};
              bitCnt   <= bitCnt + 1'b1;
            end
          end
          PARITY: begin
            // Odd requires XOR(data, parity) = 1; even requires 0.
            if (sampleTick)
              parFlag <= (^shiftReg) ^ rxS ^ (parMode == 2'b01);
          end
          STOP: begin
            if (sampleTick) begin
              DataOut      <= shiftReg;
              ParityError  <= parFlag;
              FramingError <= ~rxS;
              DataValid    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
